// File: rtl/jtkicker_obj_if.sv
// CPU object-RAM bus plus sprite ROM fetch port of the object engine.
// slave = the engine, master = the CPU/ROM side driving it.
interface jtkicker_obj_if;
    logic        cpu_cen;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rnw;
    logic        obj1_cs;
    logic        obj2_cs;
    logic [7:0]  obj_dout;
    logic [13:0] rom_addr;
    logic        rom_cs;
    logic [31:0] rom_data;
    logic        rom_ok;

    modport master (
        output cpu_cen, cpu_addr, cpu_dout, cpu_rnw, obj1_cs, obj2_cs, rom_data, rom_ok,
        input  obj_dout, rom_addr, rom_cs
    );

    modport slave (
        input  cpu_cen, cpu_addr, cpu_dout, cpu_rnw, obj1_cs, obj2_cs, rom_data, rom_ok,
        output obj_dout, rom_addr, rom_cs
    );
endinterface

// File: rtl/jtkicker_obj.sv
// Sprite engine: object RAM, per-line scanner, ROM fetch and double-buffered line buffer.
// obj_dout/pxl arrive one clk after cs/pxl_cen; the scanner waits in REQ until rom_ok.
module jtkicker_obj #(
    parameter int OBJMAX = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pxl_cen,
    jtkicker_obj_if.slave bus,
    input  logic          LHBL,
    input  logic [7:0]    vrender,
    input  logic [7:0]    hdump,
    input  logic          flip,
    output logic [7:0]    pxl
);

    typedef enum logic [2:0] {IDLE, READ, CHECK, REQ, DRAW, NEXT} state_t;

    localparam logic [6:0] IDX_LAST = 7'(OBJMAX - 1);

    logic [7:0] obj1_ram [256];
    logic [7:0] obj2_ram [256];
    logic [7:0] lbuf     [512];

    state_t      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic        sub_q, sub_d;
    logic        half_q, half_d;
    logic [2:0]  pix_q, pix_d;
    logic [7:0]  x_q, x_d, y_q, y_d, code_q, code_d, attr_q, attr_d;
    logic [3:0]  dy_q, dy_d;
    logic [31:0] word_q, word_d;
    logic        bank_q, bank_d;
    logic        lhbl_q;
    logic [7:0]  obj_dout_q, pxl_q;

    logic        cpu_we, lhbl_fall;
    logic [7:0]  cpu_a, scan_a;
    logic [7:0]  vv, dy_full, col, lb_waddr, lb_wdat;
    logic [2:0]  nib_sel;
    logic [3:0]  nibble;
    logic        lb_we;
    logic        unused_bits;

    assign cpu_we      = bus.cpu_cen && !bus.cpu_rnw;
    assign cpu_a       = bus.cpu_addr[7:0];
    assign scan_a      = {idx_q, sub_q};
    assign lhbl_fall   = lhbl_q && !LHBL;
    assign unused_bits = ^{bus.cpu_addr[10:8], attr_q[4]};

    // CPU port; obj1 wins when both selects are high
    always_ff @(posedge clk) begin
        if (cpu_we && bus.obj1_cs) obj1_ram[cpu_a] <= bus.cpu_dout;
        if (cpu_we && bus.obj2_cs && !bus.obj1_cs) obj2_ram[cpu_a] <= bus.cpu_dout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            obj_dout_q <= 8'd0;
        end else if (bus.obj1_cs) begin
            obj_dout_q <= obj1_ram[cpu_a];
        end else if (bus.obj2_cs) begin
            obj_dout_q <= obj2_ram[cpu_a];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sub_d    = sub_q;
        half_d   = half_q;
        pix_d    = pix_q;
        x_d      = x_q;
        y_d      = y_q;
        code_d   = code_q;
        attr_d   = attr_q;
        dy_d     = dy_q;
        word_d   = word_q;
        bank_d   = bank_q;
        lb_we    = 1'b0;
        vv       = flip ? ~vrender : vrender;
        dy_full  = vv - y_q;
        nib_sel  = attr_q[6] ? ~pix_q : pix_q;
        nibble   = word_q[{nib_sel, 2'b00} +: 4];
        col      = x_q + {4'd0, half_q, pix_q};
        lb_waddr = flip ? ~col : col;
        lb_wdat  = {attr_q[3:0], nibble};
        case (state_q)
            IDLE: ;
            READ: begin
                if (!sub_q) begin
                    x_d   = obj1_ram[scan_a];
                    y_d   = obj2_ram[scan_a];
                    sub_d = 1'b1;
                end else begin
                    code_d  = obj1_ram[scan_a];
                    attr_d  = obj2_ram[scan_a];
                    sub_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                dy_d    = dy_full[3:0];
                half_d  = 1'b0;
                state_d = (dy_full < 8'd16) ? REQ : NEXT;
            end
            REQ: begin
                if (bus.rom_ok) begin
                    word_d  = bus.rom_data;
                    pix_d   = 3'd0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                lb_we = (nibble != 4'd0);
                pix_d = pix_q + 3'd1;
                if (pix_q == 3'd7) begin
                    if (!half_q) begin
                        half_d  = 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (idx_q < IDX_LAST) begin
                    idx_d   = idx_q + 7'd1;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line start overrides everything, including an unfinished scan
        if (lhbl_fall) begin
            state_d = READ;
            idx_d   = 7'd0;
            sub_d   = 1'b0;
            half_d  = 1'b0;
            bank_d  = ~bank_q;
            lb_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= 7'd0;
            sub_q   <= 1'b0;
            half_q  <= 1'b0;
            pix_q   <= 3'd0;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            code_q  <= 8'd0;
            attr_q  <= 8'd0;
            dy_q    <= 4'd0;
            word_q  <= 32'd0;
            bank_q  <= 1'b0;
            lhbl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            half_q  <= half_d;
            pix_q   <= pix_d;
            x_q     <= x_d;
            y_q     <= y_d;
            code_q  <= code_d;
            attr_q  <= attr_d;
            dy_q    <= dy_d;
            word_q  <= word_d;
            bank_q  <= bank_d;
            lhbl_q  <= LHBL;
        end
    end

    assign bus.rom_cs   = (state_q == REQ);
    assign bus.rom_addr = {attr_q[5], code_q, attr_q[7] ? ~dy_q : dy_q, half_q ^ attr_q[6]};
    assign bus.obj_dout = obj_dout_q;

    // Display reads and clears the bank the scanner is not drawing
    always_ff @(posedge clk) begin
        if (pxl_cen) lbuf[{~bank_q, hdump}] <= 8'd0;
        if (lb_we) lbuf[{bank_q, lb_waddr}] <= lb_wdat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pxl_q <= 8'd0;
        end else if (pxl_cen) begin
            pxl_q <= lbuf[{~bank_q, hdump}];
        end
    end

    assign pxl = pxl_q;

endmodule

// File: tb/tb_jtkicker_obj.sv
// Bench for jtkicker_obj: ROM responder with address scoreboard, line readout with pixel scoreboard.
module tb_jtkicker_obj;
    localparam int OBJMAX = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       pxl_cen = 1'b0;
    logic       LHBL = 1'b1;
    logic       flip = 1'b0;
    logic [7:0] vrender = 8'h00;
    logic [7:0] hdump = 8'h00;
    logic [7:0] pxl;

    jtkicker_obj_if bus ();

    jtkicker_obj #(.OBJMAX(OBJMAX)) dut (
        .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen), .bus(bus),
        .LHBL(LHBL), .vrender(vrender), .hdump(hdump), .flip(flip), .pxl(pxl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom_tbl [0:16383];
    logic        rom_stall = 1'b0;
    int          rom_cnt = 0;
    logic [13:0] rom_exp;
    logic [13:0] exp_rom_q [$];
    logic [7:0]  exp_pxl_q [$];
    logic [7:0]  exp_line [0:255];

    // ROM answers two clocks after a request; every accepted address is scored
    always @(negedge clk) begin
        if (bus.rom_cs === 1'b1) rom_cnt = rom_cnt + 1;
        else rom_cnt = 0;
        bus.rom_data = rom_tbl[bus.rom_addr];
        bus.rom_ok   = (bus.rom_cs === 1'b1) && (rom_cnt >= 2) && !rom_stall;
        if (bus.rom_ok) begin
            checks++;
            if (exp_rom_q.size() == 0) begin
                errors++;
                $display("FAIL rom_addr_unexpected: got %04h, none expected", bus.rom_addr);
            end else begin
                rom_exp = exp_rom_q.pop_front();
                if (bus.rom_addr !== rom_exp) begin
                    errors++;
                    $display("FAIL rom_addr: got %04h expected %04h", bus.rom_addr, rom_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cpu_write(input logic sel2, input logic [10:0] a, input logic [7:0] d, input logic cen);
        @(negedge clk);
        bus.cpu_addr = a; bus.cpu_dout = d; bus.cpu_rnw = 1'b0;
        bus.obj1_cs = !sel2; bus.obj2_cs = sel2; bus.cpu_cen = cen;
        @(negedge clk);
        bus.obj1_cs = 1'b0; bus.obj2_cs = 1'b0; bus.cpu_cen = 1'b0; bus.cpu_rnw = 1'b1;
    endtask

    task automatic cpu_read(input logic c1, input logic c2, input logic [10:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.cpu_addr = a; bus.cpu_rnw = 1'b1; bus.obj1_cs = c1; bus.obj2_cs = c2;
        @(negedge clk);
        d = bus.obj_dout;
        bus.obj1_cs = 1'b0; bus.obj2_cs = 1'b0;
    endtask

    task automatic set_entry(input int n, input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] code, input logic [7:0] attr);
        cpu_write(1'b0, 11'(2*n),     x,    1'b1);
        cpu_write(1'b0, 11'(2*n + 1), code, 1'b1);
        cpu_write(1'b1, 11'(2*n),     y,    1'b1);
        cpu_write(1'b1, 11'(2*n + 1), attr, 1'b1);
    endtask

    task automatic clear_entries();
        for (int n = 0; n < OBJMAX; n++) set_entry(n, 8'h00, 8'hF0, 8'h00, 8'h00);
    endtask

    task automatic clear_model();
        for (int c = 0; c < 256; c++) exp_line[c] = 8'h00;
    endtask

    // Reference: what one entry contributes to the line and which ROM words it fetches
    task automatic model_entry(input logic [7:0] x, input logic [7:0] y, input logic [7:0] code,
                               input logic [7:0] attr, input logic [7:0] vr, input logic flp);
        logic [7:0]  vv, dy, c, colm;
        logic [13:0] a;
        logic [31:0] w;
        logic [3:0]  nb;
        logic        hb;
        int          p;
        vv = flp ? ~vr : vr;
        dy = vv - y;
        if (dy < 8'd16) begin
            for (int h = 0; h < 2; h++) begin
                hb = (h != 0);
                a = {attr[5], code, attr[7] ? ~dy[3:0] : dy[3:0], hb ^ attr[6]};
                exp_rom_q.push_back(a);
                w = rom_tbl[a];
                for (int i = 0; i < 8; i++) begin
                    p    = attr[6] ? 7 - i : i;
                    nb   = w[4*p +: 4];
                    c    = x + 8'(8*h + i);
                    colm = flp ? 8'd255 - c : c;
                    if (nb != 4'd0) exp_line[colm] = {attr[3:0], nb};
                end
            end
        end
    endtask

    task automatic scan_line(input logic [7:0] vr);
        @(negedge clk);
        vrender = vr; LHBL = 1'b0;
        repeat (4) @(negedge clk);
        LHBL = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (exp_rom_q.size() != 0) begin
            errors++;
            $display("FAIL scan_done: %0d ROM fetches still outstanding, expected 0", exp_rom_q.size());
            exp_rom_q.delete();
        end
    endtask

    task automatic readout(input logic do_check);
        logic [7:0] e;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            hdump = 8'(c); pxl_cen = 1'b1;
            if (do_check) exp_pxl_q.push_back(exp_line[c]);
            @(negedge clk);
            pxl_cen = 1'b0;
            if (do_check) begin
                e = exp_pxl_q.pop_front();
                checks++;
                if (pxl !== e) begin
                    errors++;
                    $display("FAIL pxl[%02h]: got %02h expected %02h", c, pxl, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.cpu_cen = 1'b0; bus.cpu_addr = '0; bus.cpu_dout = '0; bus.cpu_rnw = 1'b1;
        bus.obj1_cs = 1'b0; bus.obj2_cs = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.obj_dout !== 8'h00) begin errors++; $display("FAIL reset_obj_dout: got %02h expected 00", bus.obj_dout); end
        if (pxl !== 8'h00) begin errors++; $display("FAIL reset_pxl: got %02h expected 00", pxl); end
        if (bus.rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b expected 0", bus.rom_cs); end
        if (bus.rom_addr !== 14'h0) begin errors++; $display("FAIL reset_rom_addr: got %04h expected 0000", bus.rom_addr); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cpu_ram();
        logic [7:0] d;
        cpu_write(1'b0, 11'h013, 8'hA5, 1'b1);
        cpu_write(1'b1, 11'h013, 8'h5A, 1'b1);
        cpu_read(1'b0, 1'b1, 11'h013, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL obj2_readback: got %02h expected 5a", d); end
        cpu_read(1'b1, 1'b0, 11'h013, d);
        checks++;
        if (d !== 8'hA5) begin errors++; $display("FAIL obj1_untouched: got %02h expected a5", d); end
        cpu_write(1'b1, 11'h013, 8'hFF, 1'b0);
        cpu_read(1'b0, 1'b1, 11'h013, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL write_needs_cen: got %02h expected 5a", d); end
        cpu_write(1'b1, 11'h713, 8'h3C, 1'b1);
        cpu_read(1'b0, 1'b1, 11'h013, d);
        checks++;
        if (d !== 8'h3C) begin errors++; $display("FAIL addr_high_ignored: got %02h expected 3c", d); end
        cpu_read(1'b1, 1'b1, 11'h013, d);
        checks++;
        if (d !== 8'hA5) begin errors++; $display("FAIL obj1_priority: got %02h expected a5", d); end
    endtask

    task automatic test_basic_draw();
        clear_entries();
        set_entry(0, 8'h20, 8'h10, 8'h0A, 8'h03);
        rom_tbl[14'h148] = 32'h87654321;
        rom_tbl[14'h149] = 32'hFEDCBA98;
        clear_model();
        exp_rom_q.push_back(14'h148);
        exp_rom_q.push_back(14'h149);
        for (int i = 0; i < 8; i++) begin
            exp_line[8'h20 + i] = 8'h31 + 8'(i);
            exp_line[8'h28 + i] = 8'h38 + 8'(i);
        end
        scan_line(8'h14);
        scan_line(8'h80);
        readout(1'b1);
    endtask

    task automatic test_hflip();
        clear_entries();
        set_entry(0, 8'h20, 8'h10, 8'h0A, 8'h43);
        clear_model();
        model_entry(8'h20, 8'h10, 8'h0A, 8'h43, 8'h14, 1'b0);
        scan_line(8'h14);
        scan_line(8'h80);
        readout(1'b1);
    endtask

    task automatic test_wrap_flip(input logic flp);
        logic [7:0] vr;
        vr = flp ? 8'hEB : 8'h14;
        flip = flp;
        clear_entries();
        set_entry(0, 8'hFC, 8'h10, 8'h0A, 8'h03);
        clear_model();
        model_entry(8'hFC, 8'h10, 8'h0A, 8'h03, vr, flp);
        scan_line(vr);
        scan_line(8'h80);
        readout(1'b1);
        flip = 1'b0;
    endtask

    task automatic test_abort();
        clear_entries();
        set_entry(1, 8'h50, 8'h10, 8'h0A, 8'h03);
        clear_model();
        model_entry(8'h50, 8'h10, 8'h0A, 8'h03, 8'h14, 1'b0);
        rom_stall = 1'b1;
        @(negedge clk);
        vrender = 8'h14; LHBL = 1'b0;
        repeat (2) @(negedge clk);
        LHBL = 1'b1;
        repeat (10) @(negedge clk);
        checks += 2;
        if (bus.rom_cs !== 1'b1) begin errors++; $display("FAIL stall_rom_cs: got %b expected 1", bus.rom_cs); end
        if (bus.rom_addr !== 14'h148) begin errors++; $display("FAIL stall_rom_addr: got %04h expected 0148", bus.rom_addr); end
        @(negedge clk);
        LHBL = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rom_cs !== 1'b0) begin errors++; $display("FAIL abort_rom_cs_drop: got %b expected 0", bus.rom_cs); end
        LHBL = 1'b1;
        repeat (10) @(negedge clk);
        checks += 2;
        if (bus.rom_cs !== 1'b1) begin errors++; $display("FAIL restart_rom_cs: got %b expected 1", bus.rom_cs); end
        if (bus.rom_addr !== 14'h148) begin errors++; $display("FAIL restart_rom_addr: got %04h expected 0148", bus.rom_addr); end
        rom_stall = 1'b0;
        repeat (300) @(negedge clk);
        checks++;
        if (exp_rom_q.size() != 0) begin
            errors++;
            $display("FAIL abort_scan_done: %0d fetches outstanding, expected 0", exp_rom_q.size());
            exp_rom_q.delete();
        end
        scan_line(8'h80);
        readout(1'b1);
    endtask

    task automatic test_overlap();
        clear_entries();
        set_entry(1, 8'h40, 8'h10, 8'h20, 8'h01);
        set_entry(OBJMAX - 1, 8'h40, 8'h10, 8'h30, 8'h02);
        rom_tbl[14'h408] = 32'h99999999;
        rom_tbl[14'h409] = 32'h99999999;
        rom_tbl[14'h608] = 32'h0A0A0A0A;
        rom_tbl[14'h609] = 32'h00000000;
        clear_model();
        model_entry(8'h40, 8'h10, 8'h20, 8'h01, 8'h14, 1'b0);
        model_entry(8'h40, 8'h10, 8'h30, 8'h02, 8'h14, 1'b0);
        checks += 2;
        if (exp_line[8'h40] !== 8'h2A) begin errors++; $display("FAIL overlap_model_hi: got %02h expected 2a", exp_line[8'h40]); end
        if (exp_line[8'h41] !== 8'h19) begin errors++; $display("FAIL overlap_model_lo: got %02h expected 19", exp_line[8'h41]); end
        scan_line(8'h14);
        scan_line(8'h80);
        readout(1'b1);
        clear_model();
        scan_line(8'h80);
        scan_line(8'h80);
        readout(1'b1);
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) rom_tbl[a] = 32'h0;
        test_reset();
        test_cpu_ram();
        clear_entries();
        scan_line(8'h80);
        readout(1'b0);
        scan_line(8'h80);
        readout(1'b0);
        test_basic_draw();
        test_hflip();
        test_wrap_flip(1'b0);
        test_wrap_flip(1'b1);
        test_abort();
        test_overlap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
